masked_share_pipe: RTL
======================

Name: masked_share_pipe

Overview:
- Parametrised, elastic, valid/ready pipeline register for d-share masked data.
- Successor to the single-stage optimisation-barrier register: configurable depth, share count and share width, plus backpressure and an occupancy count.
- Each share bit passes register-to-register with no logic combining shares, so the block also acts as a glitch and synthesis barrier.
- Sits between masked gadgets in the AES datapath wherever latency balancing or stalling is needed.

Parameters:
- d, 2, number of shares (≥1).
- W, 8, bits per share (≥1).
- DEPTH, 2, number of register stages (≥1).
- CLEAR_ON_POP, 1, when 1 a stage whose word leaves without replacement is zeroed.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  pipe accepts a word this cycle.
- in_shares  in  d*W  share i occupies bits [i*W +: W].
- out_valid  out  1  last stage holds a word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_shares  out  d*W  last-stage data, driven directly from flops.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset
  - Stages are numbered 0 (input) to DEPTH-1 (output).
  - rst high at a clock edge clears all stage valid bits and all data registers to 0.
  - After that edge: out_valid=0, out_shares=0, occupancy=0, in_ready=1.
  - rst dominates in_valid and out_ready in the same cycle. A word in flight at reset is dropped.
- Stage advance rules
  - take[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - take[k] = ~v[k] | (v[k+1]... no: take[k] = ~v[k] | take[k+1], for k < DEPTH-1.
  - in_ready = take[0]. This is a combinational ready chain; out_ready→in_ready is a combinational path by design.
- On a clock edge with no reset
  - Stage 0 loads in_shares and sets v[0]=in_valid when take[0].
  - Stage k>0 loads stage k-1 data and valid when take[k].
  - Data registers are enabled only on load with a valid source. They hold otherwise.
  - With CLEAR_ON_POP=1, a stage whose valid word moves on and receives no valid word has its data zeroed in the same edge.
- Throughput and latency
  - Bubbles collapse: an empty stage always accepts from its predecessor.
  - Latency is DEPTH cycles: a word accepted at edge t appears on out_shares/out_valid after edge t+DEPTH-1 with no backpressure.
  - Throughput is 1 word/cycle.
  - Full pipe (all v=1) with out_ready=0: in_ready=0 and all stages hold.
  - Simultaneous pop and push on a full pipe: both occur and occupancy is unchanged.
- Occupancy = popcount(v), registered-consistent (derived from the flops). It is never greater than DEPTH.
- Data transfer
  - out_shares = data[DEPTH-1] whenever out_valid. When out_valid=0 it is 0 after reset, or after a pop with CLEAR_ON_POP=1.
  - No cross-share logic. Each share bit passes through its own flop chain; only valid/enable logic is shared.

Decomposition:
- Package: default values of d, W and DEPTH; a width helper for occupancy ($clog2(DEPTH+1)); a share-slicing index constant.
- Sub-module share_pipe_stage: one stage with a d*W data register, a valid flop, load/clear enables and synchronous reset.
- masked_share_pipe instantiates DEPTH stages via generate, and builds the take chain and popcount.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → out_valid=0, out_shares=0, occupancy=0, in_ready=1.
- Streaming (d=2, W=8, DEPTH=2), out_ready=1: push 0xA55A, 0x3CC3, 0x0FF0 on consecutive cycles → same words on out_shares in order, the first valid 2 cycles after acceptance, no gaps.
- Backpressure: out_ready=0, push 3 words → first 2 accepted, occupancy=2, in_ready=0, third held. Then out_ready=1 → 0xA55A, 0x3CC3 and the third word out in order with no loss or duplicate.
- Full push+pop: pipe full, in_valid=1 and out_ready=1 for 4 cycles → one word out per cycle, occupancy stays 2.
- CLEAR_ON_POP=1: single word 0x1234 passes and drains → every stage data register reads 0 afterwards. With CLEAR_ON_POP=0 the last stage retains 0x1234 with out_valid=0.
- Reset mid-operation: pipe holding 2 words, rst=1 with in_valid=1 and out_ready=1 → next cycle occupancy=0, out_valid=0, out_shares=0, and no word accepted.

Source files
------------

// File: rtl/masked_share_pipe_pkg.sv
// Shared defaults and width helpers for the masked share pipeline.
package masked_share_pipe_pkg;

    // Default geometry: two shares of one byte, two register stages.
    localparam int unsigned D_DEFAULT     = 2;
    localparam int unsigned W_DEFAULT     = 8;
    localparam int unsigned DEPTH_DEFAULT = 2;

    // Lowest bit of the first share inside a packed share vector.
    localparam int unsigned SHARE_BASE_LSB = 0;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Lowest bit of share idx when each share is w bits wide.
    function automatic int unsigned share_lsb(input int unsigned idx, input int unsigned w);
        return SHARE_BASE_LSB + idx * w;
    endfunction

endpackage

// File: rtl/masked_share_pipe_stage.sv
// One elastic stage: a flat d*W data register plus its valid flag.
// Shares are never combined here; every data bit has its own flop.
module share_pipe_stage
    import masked_share_pipe_pkg::*;
#(
    parameter int unsigned WIDTH        = D_DEFAULT * W_DEFAULT,
    parameter bit          CLEAR_ON_POP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: data loads only from a valid source; a departing word
    // with nothing behind it optionally wipes the register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = src_valid_i;
            if (src_valid_i) begin
                data_d = src_data_i;
            end else if (CLEAR_ON_POP && valid_q) begin
                data_d = '0;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/masked_share_pipe.sv
// Elastic valid/ready pipeline for d-share masked words. Each share bit
// runs through its own flop chain; only valid/enable logic is shared.
module masked_share_pipe
    import masked_share_pipe_pkg::*;
#(
    parameter int unsigned d            = D_DEFAULT,
    parameter int unsigned W            = W_DEFAULT,
    parameter int unsigned DEPTH        = DEPTH_DEFAULT,
    parameter bit          CLEAR_ON_POP = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [d*W-1:0]                  in_shares,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [d*W-1:0]                  out_shares,
    output logic [occ_width(DEPTH)-1:0]     occupancy
);

    localparam int unsigned DW    = d * W;
    localparam int unsigned OCC_W = occ_width(DEPTH);

    if (d < 1)     begin : g_bad_d     $error("d must be at least 1");     end
    if (W < 1)     begin : g_bad_w     $error("W must be at least 1");     end
    if (DEPTH < 1) begin : g_bad_depth $error("DEPTH must be at least 1"); end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] take;
    logic [DW-1:0]    stage_data [DEPTH];
    logic [OCC_W-1:0] occ_sum;

    // Ready chain from the output back to the input; a stage takes when it
    // is empty or its successor takes, so bubbles always collapse.
    always_comb begin
        take          = '0;
        take[DEPTH-1] = out_ready | ~v[DEPTH-1];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            take[DEPTH-1-i] = ~v[DEPTH-1-i] | take[DEPTH-i];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          src_valid;
        logic [DW-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_shares;
        end else begin : g_body
            assign src_valid = v[k-1];
            assign src_data  = stage_data[k-1];
        end

        share_pipe_stage #(
            .WIDTH        (DW),
            .CLEAR_ON_POP (CLEAR_ON_POP)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .load_i      (take[k]),
            .src_valid_i (src_valid),
            .src_data_i  (src_data),
            .valid_o     (v[k]),
            .data_o      (stage_data[k])
        );
    end

    // Occupancy is the popcount of the stage valid flops.
    always_comb begin
        occ_sum = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(v[i]);
        end
    end

    assign in_ready   = take[0];
    assign out_valid  = v[DEPTH-1];
    assign out_shares = stage_data[DEPTH-1];
    assign occupancy  = occ_sum;

endmodule
